sha256_msg_sched: RTL

//  Message-schedule producer for the SHA-256 round core: supplies the per-round Wt/Kt pair it consumes.

---
 rtl/sha256_msg_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule producer.
// Latches one 512-bit padded block on start_i and then presents W_t / K_t,
// one round per clock, for t = 0..NUM_ROUNDS-1. The schedule is generated
// in a 16-word sliding window: w_reg[0] always holds W_t, and the word
// shifted into w_reg[15] is W_{t+16}.
module sha256_msg_sched #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [511:0] block_i,
    output logic [31:0]  Wt_o,
    output logic [31:0]  Kt_o,
    output logic [5:0]   round_o,
    output logic         valid_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int WORDS = 16;
    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    // FIPS 180-4 SHA-256 round constants
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [5:0]  t_reg;
    logic        valid_reg;
    logic        done_reg;
    logic [31:0] w_reg   [WORDS];
    logic [31:0] w_load  [WORDS];
    logic [31:0] w_shift [WORDS];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Block words (big-endian: word 0 is the top 32 bits) and the next window
    // contents: a one-word shift with the new schedule word entering at the top.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_window
            assign w_load[gi] = block_i[511 - 32*gi -: 32];
            if (gi < WORDS - 1) begin : g_shift
                assign w_shift[gi] = w_reg[gi + 1];
            end else begin : g_new
                assign w_shift[gi] = small_sigma1(w_reg[14]) + w_reg[9]
                                   + small_sigma0(w_reg[1]) + w_reg[0];
            end
        end
    endgenerate

    // Control FSM, round counter, window and registered valid/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            t_reg     <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                w_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg <= RUN;
                        t_reg     <= '0;
                        valid_reg <= 1'b1;
                        for (int i = 0; i < WORDS; i++) begin
                            w_reg[i] <= w_load[i];
                        end
                    end
                end
                RUN: begin
                    if (start_i) begin
                        // Restart: the running block is abandoned without done
                        t_reg     <= '0;
                        valid_reg <= 1'b1;
                        for (int i = 0; i < WORDS; i++) begin
                            w_reg[i] <= w_load[i];
                        end
                    end else begin
                        for (int i = 0; i < WORDS; i++) begin
                            w_reg[i] <= w_shift[i];
                        end
                        if (t_reg == LAST_T) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            t_reg <= t_reg + 6'd1;
                        end
                    end
                end
                DONE: begin
                    if (start_i) begin
                        state_reg <= RUN;
                        t_reg     <= '0;
                        valid_reg <= 1'b1;
                        for (int i = 0; i < WORDS; i++) begin
                            w_reg[i] <= w_load[i];
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come only from registered state; zeroed outside a valid round
    always_comb begin
        Wt_o    = '0;
        Kt_o    = '0;
        round_o = '0;
        valid_o = valid_reg;
        busy_o  = valid_reg;
        done_o  = done_reg;
        if (valid_reg) begin
            Wt_o    = w_reg[0];
            Kt_o    = K_ROM[t_reg];
            round_o = t_reg;
        end
    end

endmodule
